// File: rtl/intr_sched_pkg.sv
// Shared definitions for the interrupt scheduler: FSM state encoding and default source count.
// Included by the scheduler and by any CSR logic that decodes its debug state.
package intr_sched_pkg;

  localparam int NSRC_DEF = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_ARM  = 2'b01,
    ST_SVC  = 2'b10
  } state_t;

endpackage

// File: rtl/intr_sched_if.sv
// Signal bundle between the core pipeline/CSR side (master) and the interrupt scheduler (slave).
// intr_take is a single-cycle qualifier: valid only while intr_req and vld_d are both high.
interface intr_sched_if
  import intr_sched_pkg::*;
#(
  parameter int NSRC = NSRC_DEF,
  parameter int CW   = $clog2(NSRC)
) ();

  logic [NSRC-1:0] src_intr_sync;
  logic [NSRC-1:0] intr_en;
  logic            glb_ie;
  logic            vld_d;
  logic            ertn_w;
  logic            intr_req;
  logic            intr_take;
  logic [CW-1:0]   intr_cause;
  logic            in_service;
  logic [NSRC-1:0] pend_vec;
  state_t          dbg_state;

  modport master (
    output src_intr_sync, intr_en, glb_ie, vld_d, ertn_w,
    input  intr_req, intr_take, intr_cause, in_service, pend_vec, dbg_state
  );

  modport slave (
    input  src_intr_sync, intr_en, glb_ie, vld_d, ertn_w,
    output intr_req, intr_take, intr_cause, in_service, pend_vec, dbg_state
  );

endinterface

// File: rtl/intr_sched_prio_enc.sv
// Combinational fixed-priority encoder: the lowest set index wins.
module intr_sched_prio_enc #(
  parameter int NSRC = 8,
  parameter int CW   = $clog2(NSRC)
) (
  input  logic [NSRC-1:0] i_req,
  output logic [CW-1:0]   o_idx,
  output logic            o_any
);

  always_comb begin
    o_idx = '0;
    o_any = |i_req;
    // Scan from the top so the lowest index is written last.
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (i_req[i]) o_idx = i[CW-1:0];
    end
  end

endmodule

// File: rtl/intr_sched.sv
// Non-nesting fixed-priority interrupt sequencer: registers pending lines, arms the winner,
// hands it to decode on a valid instruction and holds it until the handler's ertn retires.
module intr_sched
  import intr_sched_pkg::*;
#(
  parameter int NSRC = NSRC_DEF,
  parameter int CW   = $clog2(NSRC)
) (
  input  logic        clk,
  input  logic        reset,
  intr_sched_if.slave bus
);

  logic [NSRC-1:0] r_pend_q;
  logic [CW-1:0]   r_cause_q;
  state_t          r_state;
  state_t          w_next_state;
  logic [CW-1:0]   w_idx;
  logic            w_any;
  logic            w_armed_live;
  logic            w_take;

  intr_sched_prio_enc #(.NSRC(NSRC), .CW(CW)) u_prio_enc (
    .i_req (r_pend_q),
    .o_idx (w_idx),
    .o_any (w_any)
  );

  // Level-sensitive capture; a line that drops simply disappears from the pending set.
  always_ff @(posedge clk) begin
    if (reset) r_pend_q <= '0;
    else       r_pend_q <= bus.src_intr_sync & bus.intr_en;
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_next_state;
  end

  // Cause is latched only on IDLE->ARM and stays frozen through SVC (no preemption).
  always_ff @(posedge clk) begin
    if (reset)                                               r_cause_q <= '0;
    else if (r_state == ST_IDLE && w_next_state == ST_ARM)   r_cause_q <= w_idx;
  end

  assign w_armed_live = r_pend_q[r_cause_q] & bus.glb_ie;

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: if (w_any && bus.glb_ie) w_next_state = ST_ARM;
      ST_ARM: begin
        if (w_take)             w_next_state = ST_SVC;
        else if (!w_armed_live) w_next_state = ST_IDLE;
      end
      ST_SVC:  if (bus.ertn_w) w_next_state = ST_IDLE;
      default: w_next_state = ST_IDLE;
    endcase
  end

  always_comb begin
    w_take         = (r_state == ST_ARM) & bus.vld_d & w_armed_live;
    bus.intr_take  = w_take;
    bus.intr_req   = (r_state == ST_ARM);
    bus.in_service = (r_state == ST_SVC);
    bus.intr_cause = r_cause_q;
    bus.pend_vec   = r_pend_q;
    bus.dbg_state  = r_state;
  end

endmodule
